// File: rtl/nexys_starship_bm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nexys_starship_bm_ctrl
//  Purpose  : Bottom-hatch monster controller for the Nexys Starship game.
//             Watches for a bottom monster, kills it when the player fires
//             while aiming at the bottom hatch, enforces a reload cooldown,
//             and breaks the hull if a monster stays present too long.
//  Options  : NEXYS_STARSHIP_BM_SCORE_EN - when defined, an 8-bit saturating
//             kill counter drives 'score'; otherwise 'score' is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module nexys_starship_bm_ctrl #(
  parameter int TIMEOUT  = 100_000_000,
  parameter int RELOAD   = 25_000_000,
  parameter int KILL_LEN = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       btm_monster_sm,
  input  logic       shoot,
  input  logic       aim_btm,
  output logic       btm_monster_ctrl,
  output logic       btm_broken,
  output logic       game_over,
  output logic [7:0] score,
  output logic       q_Idle,
  output logic       q_Watch,
  output logic       q_Kill,
  output logic       q_Reload,
  output logic       q_Over
);

  // Counter widths are sized to hold the parameter value itself so the
  // presence timer can saturate at TIMEOUT without wrapping.
  localparam int PRES_W = $clog2(TIMEOUT + 1);
  localparam int REL_W  = $clog2(RELOAD + 1);
  localparam int KILL_W = $clog2(KILL_LEN + 1);

  localparam logic [PRES_W-1:0] c_PRES_LAST = PRES_W'(TIMEOUT - 1);
  localparam logic [PRES_W-1:0] c_PRES_MAX  = PRES_W'(TIMEOUT);
  localparam logic [REL_W-1:0]  c_REL_LAST  = REL_W'(RELOAD - 1);
  localparam logic [KILL_W-1:0] c_KILL_LAST = KILL_W'(KILL_LEN - 1);

  // One-hot state encoding; each bit maps directly to a q_* flag.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_WATCH  = 5'b00010,
    S_KILL   = 5'b00100,
    S_RELOAD = 5'b01000,
    S_OVER   = 5'b10000
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PRES_W-1:0]   r_pres;
  logic [PRES_W-1:0]   w_pres_next;
  logic [REL_W-1:0]    r_rel;
  logic [REL_W-1:0]    w_rel_next;
  logic [KILL_W-1:0]   r_kill;
  logic [KILL_W-1:0]   w_kill_next;
  logic                r_ctrl;
  logic                r_broken;
  logic                r_game_over;
  logic                w_counting;
  logic                w_timeout;
  logic                w_kill_shot;
  logic                w_keep_alive;
  logic                w_kill_entry;
  logic                w_game_start;

  // State register and all internal counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pres  <= '0;
      r_rel   <= '0;
      r_kill  <= '0;
    end else begin
      r_state <= w_next;
      r_pres  <= w_pres_next;
      r_rel   <= w_rel_next;
      r_kill  <= w_kill_next;
    end
  end

  // Next-state decode plus next values for the presence, kill and reload timers.
  always_comb begin
    w_next      = r_state;
    w_pres_next = '0;
    w_rel_next  = '0;
    w_kill_next = '0;

    // The presence timer only runs while the monster is visible and the
    // player is in a position to react (watching or reloading).
    w_counting  = ((r_state == S_WATCH) || (r_state == S_RELOAD)) && btm_monster_sm;
    w_timeout   = w_counting && (r_pres == c_PRES_LAST);
    w_kill_shot = shoot && aim_btm && btm_monster_sm;

    case (r_state)
      S_IDLE: begin
        if (play_flag) w_next = S_WATCH;
      end
      S_WATCH: begin
        // A kill in the final timeout cycle still saves the hull.
        if (!play_flag)       w_next = S_IDLE;
        else if (w_kill_shot) w_next = S_KILL;
        else if (w_timeout)   w_next = S_OVER;
      end
      S_KILL: begin
        if (!play_flag)                 w_next = S_IDLE;
        else if (r_kill == c_KILL_LAST) w_next = S_RELOAD;
      end
      S_RELOAD: begin
        // Shots are ignored here, but a lingering monster can still time out.
        if (!play_flag)               w_next = S_IDLE;
        else if (w_timeout)           w_next = S_OVER;
        else if (r_rel == c_REL_LAST) w_next = S_WATCH;
      end
      S_OVER: begin
        w_next = S_OVER;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Presence timer carries across WATCH<->RELOAD while the monster stays;
    // any drop of the monster, a kill, or a return to IDLE clears it.
    if (w_counting && (w_next != S_IDLE) && (w_next != S_KILL)) begin
      if (r_pres == c_PRES_MAX) w_pres_next = r_pres;
      else                      w_pres_next = r_pres + 1'b1;
    end

    // Dwell counters restart from zero on every entry into their state.
    if ((r_state == S_KILL) && (w_next == S_KILL))
      w_kill_next = r_kill + 1'b1;
    if ((r_state == S_RELOAD) && (w_next == S_RELOAD))
      w_rel_next = r_rel + 1'b1;
  end

  assign w_keep_alive = (w_next == S_WATCH) || (w_next == S_RELOAD);
  assign w_kill_entry = (w_next == S_KILL) && (r_state != S_KILL);
  assign w_game_start = (r_state == S_IDLE) && (w_next == S_WATCH);

  // Registered keep-alive and sticky loss flags, aligned with the state they describe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ctrl      <= 1'b0;
      r_broken    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_ctrl <= w_keep_alive;
      if (w_next == S_OVER) begin
        r_broken    <= 1'b1;
        r_game_over <= 1'b1;
      end
    end
  end

`ifdef NEXYS_STARSHIP_BM_SCORE_EN
  logic [7:0] r_score;

  // Saturating kill counter; a fresh game start clears it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_score <= 8'd0;
    end else if (w_game_start) begin
      r_score <= 8'd0;
    end else if (w_kill_entry && (r_score != 8'hFF)) begin
      r_score <= r_score + 8'd1;
    end
  end

  assign score = r_score;
`else
  logic w_score_unused;

  assign w_score_unused = w_kill_entry ^ w_game_start;
  assign score          = 8'd0 & {8{w_score_unused}};
`endif

  assign btm_monster_ctrl = r_ctrl;
  assign btm_broken       = r_broken;
  assign game_over        = r_game_over;

  assign q_Idle   = (r_state == S_IDLE);
  assign q_Watch  = (r_state == S_WATCH);
  assign q_Kill   = (r_state == S_KILL);
  assign q_Reload = (r_state == S_RELOAD);
  assign q_Over   = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_bm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nexys_starship_bm_ctrl
//  Purpose  : Self-checking bench for nexys_starship_bm_ctrl with
//             TIMEOUT=8, RELOAD=4, KILL_LEN=2. A behavioural model pushes the
//             expected outputs per clock edge; each test drains and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_bm_ctrl;

  localparam int TO = 8;
  localparam int RL = 4;
  localparam int KL = 2;

`ifdef NEXYS_STARSHIP_BM_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  localparam int ST_I = 0;
  localparam int ST_W = 1;
  localparam int ST_K = 2;
  localparam int ST_R = 3;
  localparam int ST_O = 4;

  logic       Clk;
  logic       Reset;
  logic       play_flag;
  logic       btm_monster_sm;
  logic       shoot;
  logic       aim_btm;
  logic       btm_monster_ctrl;
  logic       btm_broken;
  logic       game_over;
  logic [7:0] score;
  logic       q_Idle, q_Watch, q_Kill, q_Reload, q_Over;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_st, m_pres, m_kcnt, m_rcnt, m_score;
  bit m_brk, m_ctrl;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  nexys_starship_bm_ctrl #(
    .TIMEOUT (TO),
    .RELOAD  (RL),
    .KILL_LEN(KL)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .play_flag       (play_flag),
    .btm_monster_sm  (btm_monster_sm),
    .shoot           (shoot),
    .aim_btm         (aim_btm),
    .btm_monster_ctrl(btm_monster_ctrl),
    .btm_broken      (btm_broken),
    .game_over       (game_over),
    .score           (score),
    .q_Idle          (q_Idle),
    .q_Watch         (q_Watch),
    .q_Kill          (q_Kill),
    .q_Reload        (q_Reload),
    .q_Over          (q_Over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Packed view: {q_Over,q_Reload,q_Kill,q_Watch,q_Idle, ctrl, broken, over, score}
  function automatic logic [15:0] obs_vec();
    return {q_Over, q_Reload, q_Kill, q_Watch, q_Idle,
            btm_monster_ctrl, btm_broken, game_over, score};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [4:0] oh;
    logic [7:0] sc;
    oh       = 5'b00000;
    oh[m_st] = 1'b1;
    sc       = SCORE_EN ? 8'(m_score) : 8'd0;
    return {oh, m_ctrl, m_brk, m_brk, sc};
  endfunction

  task automatic model_reset();
    m_st = ST_I; m_pres = 0; m_kcnt = 0; m_rcnt = 0; m_score = 0;
    m_brk = 1'b0; m_ctrl = 1'b0;
  endtask

  // Reference behaviour for one rising edge given the inputs held before it.
  task automatic model_edge(input bit pf, input bit sm, input bit sh, input bit aim);
    int ns;
    bit cnt;
    bit tmo;
    ns  = m_st;
    cnt = ((m_st == ST_W) || (m_st == ST_R)) && sm;
    tmo = cnt && (m_pres == TO - 1);
    case (m_st)
      ST_I: if (pf) ns = ST_W;
      ST_W: begin
        if (!pf) ns = ST_I;
        else if (sh && aim && sm) ns = ST_K;
        else if (tmo) ns = ST_O;
      end
      ST_K: begin
        if (!pf) ns = ST_I;
        else if (m_kcnt == KL - 1) ns = ST_R;
      end
      ST_R: begin
        if (!pf) ns = ST_I;
        else if (tmo) ns = ST_O;
        else if (m_rcnt == RL - 1) ns = ST_W;
      end
      default: ns = m_st;
    endcase
    if (m_st == ST_I && ns == ST_W) m_score = 0;
    else if (ns == ST_K && m_st != ST_K && m_score < 255) m_score = m_score + 1;
    if (cnt && ns != ST_I && ns != ST_K) m_pres = (m_pres < TO) ? m_pres + 1 : TO;
    else m_pres = 0;
    m_kcnt = (m_st == ST_K && ns == ST_K) ? m_kcnt + 1 : 0;
    m_rcnt = (m_st == ST_R && ns == ST_R) ? m_rcnt + 1 : 0;
    if (ns == ST_O) m_brk = 1'b1;
    m_ctrl = (ns == ST_W) || (ns == ST_R);
    m_st   = ns;
    exp_q.push_back(exp_vec());
  endtask

  // Drive one cycle of inputs, record expectation, clock, capture DUT outputs.
  task automatic cycle(input bit pf, input bit sm, input bit sh, input bit aim);
    play_flag      = pf;
    btm_monster_sm = sm;
    shoot          = sh;
    aim_btm        = aim;
    model_edge(pf, sm, sh, aim);
    @(posedge Clk);
    #1;
    obs_q.push_back(obs_vec());
  endtask

  task automatic test_reset();
    logic [15:0] e, o;
    Reset = 1'b1; play_flag = 1'b0; btm_monster_sm = 1'b0; shoot = 1'b0; aim_btm = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_state: got=%h want=%h", obs_vec(), exp_vec());
    end
    Reset = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_idle: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_start();
    logic [15:0] e, o;
    cycle(1, 0, 0, 0);
    n_checks++;
    if (!(q_Watch === 1'b1 && btm_monster_ctrl === 1'b1)) begin
      n_errors++;
      $display("FAIL start_watch: got q_Watch=%b ctrl=%b want 1 1", q_Watch, btm_monster_ctrl);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL start: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_kill();
    logic [15:0] e, o;
    int n_kill, n_rel, n_low;
    n_kill = 0; n_rel = 0; n_low = 0;
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 1);
    n_kill += int'(q_Kill); n_rel += int'(q_Reload); n_low += int'(!btm_monster_ctrl);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0);
      n_kill += int'(q_Kill); n_rel += int'(q_Reload); n_low += int'(!btm_monster_ctrl);
    end
    n_checks++;
    if (n_kill != 2 || n_low != 2 || n_rel != 4 || q_Watch !== 1'b1) begin
      n_errors++;
      $display("FAIL kill_timing: got kill=%0d low=%0d reload=%0d watch=%b want 2 2 4 1",
               n_kill, n_low, n_rel, q_Watch);
    end
    n_checks++;
    if (score !== (SCORE_EN ? 8'd1 : 8'd0)) begin
      n_errors++;
      $display("FAIL kill_score: got=%0d want=%0d", score, SCORE_EN ? 1 : 0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL kill: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_ignored_shots();
    logic [15:0] e, o;
    int n_bad;
    n_bad = 0;
    cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 0);
    cycle(1, 0, 1, 1);
    n_checks++;
    if (q_Watch !== 1'b1 || score !== (SCORE_EN ? 8'd1 : 8'd0)) begin
      n_errors++;
      $display("FAIL ignored_watch: got q_Watch=%b score=%0d want 1 %0d", q_Watch, score, SCORE_EN ? 1 : 0);
    end
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < RL; i++) begin
      if (q_Reload !== 1'b1) n_bad++;
      cycle(1, 1, 1, 1);
    end
    n_checks++;
    if (n_bad != 0 || q_Watch !== 1'b1 || score !== (SCORE_EN ? 8'd2 : 8'd0)) begin
      n_errors++;
      $display("FAIL ignored_reload: got bad=%0d q_Watch=%b score=%0d want 0 1 %0d",
               n_bad, q_Watch, score, SCORE_EN ? 2 : 0);
    end
    cycle(1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL ignored: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_kill_beats_timeout();
    logic [15:0] e, o;
    for (int i = 0; i < TO - 1; i++) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 1);
    n_checks++;
    if (q_Kill !== 1'b1 || q_Over !== 1'b0 || btm_broken !== 1'b0) begin
      n_errors++;
      $display("FAIL kill_vs_timeout: got kill=%b over=%b broken=%b want 1 0 0", q_Kill, q_Over, btm_broken);
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL kill_vs_timeout_seq: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] e, o;
    for (int i = 0; i < TO - 1; i++) cycle(1, 1, 0, 0);
    n_checks++;
    if (q_Watch !== 1'b1 || btm_broken !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_early: got watch=%b broken=%b want 1 0", q_Watch, btm_broken);
    end
    cycle(1, 1, 0, 0);
    n_checks++;
    if (q_Over !== 1'b1 || btm_broken !== 1'b1 || game_over !== 1'b1 || btm_monster_ctrl !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_over: got over=%b broken=%b game_over=%b ctrl=%b want 1 1 1 0",
               q_Over, btm_broken, game_over, btm_monster_ctrl);
    end
    for (int i = 0; i < 6; i++) cycle(bit'(i % 2), bit'($urandom_range(0, 1)), 1'b1, 1'b1);
    n_checks++;
    if (q_Over !== 1'b1 || btm_broken !== 1'b1 || game_over !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_sticky: got over=%b broken=%b game_over=%b want 1 1 1", q_Over, btm_broken, game_over);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL timeout_seq: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e, o;
    // Reset asserted between clock edges while in OVER.
    #2 Reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL async_reset_over: got=%h want=%h", obs_vec(), exp_vec());
    end
    #2 Reset = 1'b0;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 0);
    // Reset asserted mid-KILL.
    #2 Reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL async_reset_kill: got=%h want=%h", obs_vec(), exp_vec());
    end
    #2 Reset = 1'b0;
    cycle(0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL async_reset_seq: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_score_saturation();
    logic [15:0] e, o;
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 260; k++) begin
      cycle(1, 1, 1, 1);
      for (int i = 0; i < KL + RL; i++) cycle(1, 0, 0, 0);
    end
    n_checks++;
    if (score !== (SCORE_EN ? 8'd255 : 8'd0) || q_Watch !== 1'b1) begin
      n_errors++;
      $display("FAIL score_sat: got score=%0d watch=%b want %0d 1", score, q_Watch, SCORE_EN ? 255 : 0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL score_sat_seq: got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_play_drop();
    logic [15:0] e, o;
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    n_checks++;
    if (q_Idle !== 1'b1 || btm_monster_ctrl !== 1'b0 || score !== (SCORE_EN ? 8'd255 : 8'd0)) begin
      n_errors++;
      $display("FAIL drop_idle: got idle=%b ctrl=%b score=%0d want 1 0 %0d",
               q_Idle, btm_monster_ctrl, score, SCORE_EN ? 255 : 0);
    end
    cycle(1, 0, 0, 0);
    n_checks++;
    if (q_Watch !== 1'b1 || btm_monster_ctrl !== 1'b1 || score !== 8'd0) begin
      n_errors++;
      $display("FAIL drop_restart: got watch=%b ctrl=%b score=%0d want 1 1 0", q_Watch, btm_monster_ctrl, score);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL drop_seq: got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_kill();
    test_ignored_shots();
    test_kill_beats_timeout();
    test_timeout();
    test_async_reset();
    test_score_saturation();
    test_play_drop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nexys_starship_bm_ctrl.md
NEXYS_STARSHIP_BM_CTRL -- requirements
Module: nexys_starship_bm_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 100_000_000, meaning clock cycles a bottom monster may stay present before the hull breaks.
REQ-002 The block SHALL have parameter RELOAD, default 25_000_000, meaning cooldown cycles after a kill during which shots are ignored.
REQ-003 The block SHALL have parameter KILL_LEN, default 2, meaning cycles btm_monster_ctrl is held low per kill (legal range 1..15).
REQ-004 Port: Clk  input  1  system clock, all state updates on rising edge.
REQ-005 Port: Reset  input  1  reset, asynchronous, active-high.
REQ-006 Port: play_flag  input  1  game running; low returns the block to IDLE.
REQ-007 Port: btm_monster_sm  input  1  bottom monster present, driven by the bottom-monster state machine.
REQ-008 Port: shoot  input  1  single-cycle, already-debounced fire pulse.
REQ-009 Port: aim_btm  input  1  player is facing the bottom hatch.
REQ-010 Port: btm_monster_ctrl  output  1  registered keep-alive to the monster FSM; 1 = keep monster, 0 = kill it.
REQ-011 Port: btm_broken  output  1  registered, sticky; bottom hull destroyed.
REQ-012 Port: game_over  output  1  registered, sticky; game lost.
REQ-013 Port: score  output  8  registered count of bottom kills.
REQ-014 Port: q_Idle, q_Watch, q_Kill, q_Reload, q_Over  output  1 each  one-hot state flags.

Function
REQ-015 The FSM SHALL be one-hot with states IDLE, WATCH, KILL, RELOAD, OVER.
REQ-016 IDLE: btm_monster_ctrl=0, timers cleared; play_flag=1 -> WATCH next cycle.
REQ-017 WATCH: btm_monster_ctrl=1; shoot & aim_btm & btm_monster_sm -> KILL next cycle; shoot otherwise ignored.
REQ-018 KILL: btm_monster_ctrl=0 for exactly KILL_LEN cycles, then RELOAD; score increments once on entry.
REQ-019 RELOAD: btm_monster_ctrl=1; reload counter runs RELOAD cycles, then WATCH; shoot ignored.
REQ-020 OVER: btm_monster_ctrl=0, btm_broken=1, game_over=1; left only by Reset; play_flag ignored.
REQ-021 Presence timer SHALL count each cycle btm_monster_sm=1 in WATCH or RELOAD, clear when btm_monster_sm=0 or in IDLE/KILL, and saturate at TIMEOUT.
REQ-022 Timer reaching TIMEOUT-1 while counting SHALL cause OVER next cycle; btm_broken and game_over rise in that same transition.
REQ-023 Valid kill and timeout in the same WATCH cycle: kill SHALL win (KILL, timer cleared).
REQ-024 play_flag=0 in WATCH, KILL or RELOAD SHALL force IDLE next cycle, clearing timers; score retained.
REQ-025 score SHALL saturate at 255; it clears only on Reset or IDLE->WATCH transition.
REQ-026 Timer widths SHALL be $clog2(param+1) bits; no wrap-around permitted.
REQ-027 Kill latency: shoot cycle N -> btm_monster_ctrl=0 registered at edge N+1.

Reset
REQ-028 Reset SHALL force IDLE, btm_monster_ctrl=0, btm_broken=0, game_over=0, score=0, all counters 0, q_Idle=1.
REQ-029 Reset mid-KILL or in OVER SHALL take effect immediately, independent of Clk.

Configuration
REQ-030 Macro NEXYS_STARSHIP_BM_SCORE_EN defined: score counter implemented per REQ-018/025.
REQ-031 Macro NEXYS_STARSHIP_BM_SCORE_EN undefined: no score register; score tied to 8'd0; all other behaviour identical.

Verification (TIMEOUT=8, RELOAD=4, KILL_LEN=2)
REQ-032 Reset pulse mid-run -> all outputs 0, q_Idle=1 immediately; play_flag=1 -> q_Watch=1 and ctrl=1 after 1 edge.
REQ-033 Monster present, shoot+aim_btm at cycle 3 -> ctrl=0 for 2 cycles, score 0->1, q_Reload for 4 cycles, back to WATCH.
REQ-034 Monster held present, no shoot -> OVER after 8 counting cycles; btm_broken=game_over=1, stay set with play_flag toggled.
REQ-035 shoot with aim_btm=0, or during RELOAD -> no state change, score unchanged.
REQ-036 Valid shoot on timer's 8th cycle -> KILL, not OVER; 256 kills -> score stays 255.
REQ-037 play_flag dropped in RELOAD -> IDLE next cycle, ctrl=0, score held; re-raise -> score 0.
